// File: rtl/core_pkg.sv
// Shared core definitions: arbiter state encoding, default bus widths and
// the memory request-field bundle layout.
package core_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    // Default-width bundle; parameterised users mirror this field order.
    typedef struct packed {
        logic                      we;
        logic [ADDR_W_DEF-1:0]     addr;
        logic [DATA_W_DEF-1:0]     wdata;
        logic [DATA_W_DEF/8-1:0]   wstrb;
    } mem_fields_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory; data has priority,
// bounded by a consecutive-grant streak so a pending fetch cannot starve.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ARB_IDLE   | no access in flight; arbitrate eligible requesters
// ARB_BUSY_I | fetch access forwarded, waiting for mem_ready
// ARB_BUSY_D | load/store access forwarded, waiting for mem_ready
module mem_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int BW = DATA_W / 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BW-1:0]     wstrb;
    } fields_t;

    arb_state_t        state, state_nxt;
    fields_t           fields, fields_nxt;
    logic [SW-1:0]     streak, streak_nxt;
    logic              grant_i, grant_d;
    logic              i_elig, d_elig, streak_full;
    logic              mem_req_nxt, i_ready_nxt, d_ready_nxt;
    logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;

    // A requester whose ready is high this cycle still has req up; skip it.
    assign i_elig      = i_req && !i_ready;
    assign d_elig      = d_req && !d_ready;
    assign streak_full = (streak == SW'(MAX_STREAK));

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (d_elig && !(i_elig && streak_full)) begin
                    grant_d   = 1'b1;
                    state_nxt = ARB_BUSY_D;
                end else if (i_elig) begin
                    grant_i   = 1'b1;
                    state_nxt = ARB_BUSY_I;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (mem_ready) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        fields_nxt  = fields;
        streak_nxt  = streak;
        mem_req_nxt = mem_req;
        i_ready_nxt = 1'b0;
        d_ready_nxt = 1'b0;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;
        if (grant_d) begin
            mem_req_nxt = 1'b1;
            fields_nxt  = '{we: d_we, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
            if (!i_req)            streak_nxt = '0;
            else if (!streak_full) streak_nxt = streak + SW'(1);
        end else if (grant_i) begin
            mem_req_nxt = 1'b1;
            fields_nxt  = '{we: 1'b0, addr: i_addr, wdata: '0, wstrb: '0};
            streak_nxt  = '0;
        end
        if (mem_ready && state == ARB_BUSY_I) begin
            mem_req_nxt = 1'b0;
            i_ready_nxt = 1'b1;
            i_rdata_nxt = mem_rdata;
        end
        if (mem_ready && state == ARB_BUSY_D) begin
            mem_req_nxt = 1'b0;
            d_ready_nxt = 1'b1;
            d_rdata_nxt = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fields  <= '0;
            streak  <= '0;
            mem_req <= 1'b0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            fields  <= fields_nxt;
            streak  <= streak_nxt;
            mem_req <= mem_req_nxt;
            i_ready <= i_ready_nxt;
            d_ready <= d_ready_nxt;
            i_rdata <= i_rdata_nxt;
            d_rdata <= d_rdata_nxt;
        end
    end

    assign mem_we    = fields.we;
    assign mem_addr  = fields.addr;
    assign mem_wdata = fields.wdata;
    assign mem_wstrb = fields.wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small memory responder answers after a
// programmable number of wait cycles with rdata = addr + 0x503.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ready, d_req, d_we, d_ready;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb, mem_wstrb;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responder; when mem_auto is off, mem_ready follows spur_lvl.
    bit   mem_auto = 1'b1;
    bit   spur_lvl = 1'b0;
    int   mem_wait = 1;
    int   mem_cnt  = 0;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
    end
    always @(negedge clk) begin
        if (!mem_auto) begin
            mem_ready = spur_lvl;
            mem_rdata = 32'hBAD0_BAD0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (mem_req) begin
            if (mem_cnt >= mem_wait) begin
                mem_ready = 1'b1;
                mem_rdata = mem_addr + 32'h503;
                mem_cnt   = 0;
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // Grant monitor: address and cycle of every mem_req rising edge.
    int          cyc = 0;
    logic        mem_req_d = 1'b0;
    logic [31:0] grant_q[$];
    int          rise_q[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_req && !mem_req_d) begin
            grant_q.push_back(mem_addr);
            rise_q.push_back(cyc);
        end
        mem_req_d = mem_req;
    end

    initial begin
        int          lat, busy, d_done;
        bit          i_seen, d_seen, i_act, seen;
        logic [31:0] exp_order [7];
        exp_order = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h40, 32'h300, 32'h300};

        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {i_ready, d_ready, mem_req, mem_we, mem_wstrb}, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        check("rst_fields", {mem_addr, mem_wdata}, 0);
        rst = 1'b0;

        // single fetch, memory answers one cycle after mem_req rises
        i_req = 1'b1; i_addr = 32'h10; lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mem_req) begin
                check("fetch_we", {mem_we, mem_wstrb}, 0);
                check("fetch_addr", mem_addr, 32'h10);
            end
            if (i_ready) begin
                lat = k;
                break;
            end
        end
        check("fetch_latency", lat, 3);
        check("fetch_rdata", i_rdata, 32'h513);
        check("fetch_no_d_ready", d_ready, 0);
        i_req = 1'b0;
        @(negedge clk);
        check("fetch_ready_pulse", i_ready, 0);
        check("fetch_rdata_hold", i_rdata, 32'h513);

        // simultaneous first requests: D first, one idle bus cycle, then I
        grant_q.delete(); rise_q.delete();
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        i_seen = 1'b0; d_seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (d_ready) begin
                check("simul_d_rdata", d_rdata, 32'h603);
                d_req = 1'b0; d_seen = 1'b1;
            end
            if (i_ready) begin
                check("simul_i_rdata", i_rdata, 32'h543);
                i_req = 1'b0; i_seen = 1'b1;
            end
            if (i_seen && d_seen) break;
        end
        check("simul_both_done", {i_seen, d_seen}, 2'b11);
        check("simul_grants", grant_q.size(), 2);
        check("simul_first", grant_q[0], 32'h100);
        check("simul_second", grant_q[1], 32'h40);
        check("simul_gap", rise_q[1] - rise_q[0], 3);

        // store with three wait cycles; fields must stay stable
        mem_wait = 3; busy = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_req) begin
                busy++;
                check("store_we", mem_we, 1);
                check("store_addr", mem_addr, 32'h200);
                check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
                check("store_wstrb", mem_wstrb, 4'b0011);
            end
            if (d_ready) break;
        end
        check("store_d_ready", d_ready, 1);
        check("store_busy_cycles", busy, 4);
        d_req = 1'b0; d_we = 1'b0; d_wstrb = '0; d_wdata = '0;
        mem_wait = 1;
        @(negedge clk);

        // streak: D re-requests continuously; fetch is pending on every
        // cycle the arbiter could grant D, so four D grants precede the I
        grant_q.delete(); rise_q.delete();
        d_req = 1'b1; d_addr = 32'h300; i_addr = 32'h40; i_act = 1'b1; i_req = 1'b1; d_done = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (d_ready) begin
                d_done++;
                if (d_done == 6) begin
                    d_req = 1'b0; i_act = 1'b0;
                end
            end
            i_req = i_act && !d_ready;
            if (d_done == 6) break;
        end
        repeat (4) @(negedge clk);
        check("starve_d_done", d_done, 6);
        check("starve_grants", grant_q.size(), 7);
        for (int g = 0; g < 7; g++) check($sformatf("starve_order_%0d", g), grant_q[g], exp_order[g]);

        // spurious mem_ready while idle
        spur_lvl = 1'b1; mem_auto = 1'b0;
        repeat (2) @(negedge clk);
        spur_lvl = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("spur_quiet", {i_ready, d_ready, mem_req}, 0);
        end
        check("spur_i_rdata", i_rdata, 32'h543);
        check("spur_d_rdata", d_rdata, 32'h803);
        mem_auto = 1'b1;
        @(negedge clk);

        // reset while a load is in flight
        mem_wait = 20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("rstmid_busy", seen, 1);
        check("rstmid_addr", mem_addr, 32'h500);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_ctrl", {i_ready, d_ready, mem_req, mem_we, mem_wstrb}, 0);
        check("rstmid_rdata", {i_rdata, d_rdata}, 0);
        check("rstmid_fields", {mem_addr, mem_wdata}, 0);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rstmid_no_ready", {d_ready, i_ready, mem_req}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
